// File: rtl/mask_pkg.sv
// Shared definitions for the mask serializer/deserializer pair: widths,
// per-resolution beat counts, resolution codes and the deserializer FSM states.
package mask_pkg;

    localparam int OP_MASK_WIDTH    = 1080;
    localparam int IP_CHANNEL_WIDTH = 20;
    localparam int STEP_SEL0        = 16;
    localparam int STEP_SEL1        = 32;
    localparam int STEP_SEL2        = 54;
    localparam int CNT_W            = $clog2(STEP_SEL2);
    localparam int IDX_W            = $clog2(OP_MASK_WIDTH);

    typedef enum logic [1:0] {
        RES_320     = 2'b00,
        RES_640     = 2'b01,
        RES_1080    = 2'b10,
        RES_ILLEGAL = 2'b11
    } res_e;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_e;

    // The illegal code never gets latched, so its step value is irrelevant.
    function automatic logic [CNT_W-1:0] step_of(input res_e res);
        case (res)
            RES_320: step_of = CNT_W'(STEP_SEL0);
            RES_640: step_of = CNT_W'(STEP_SEL1);
            default: step_of = CNT_W'(STEP_SEL2);
        endcase
    endfunction

endpackage

// File: rtl/mask_deserializer_if.sv
// Word-input / mask-output bus of the mask deserializer. The master side
// drives words and control; the slave side is the deserializer itself.
interface mask_deserializer_if;
    import mask_pkg::*;

    logic [1:0]                  imageResolution;
    logic                        start;
    logic [IP_CHANNEL_WIDTH-1:0] DIN;
    logic                        din_valid;
    logic                        din_ready;
    logic [OP_MASK_WIDTH-1:0]    DOUT;
    logic                        mask_valid;
    logic                        mask_ack;
    logic                        err;

    modport master (
        output imageResolution, start, DIN, din_valid, mask_ack,
        input  din_ready, DOUT, mask_valid, err
    );

    modport slave (
        input  imageResolution, start, DIN, din_valid, mask_ack,
        output din_ready, DOUT, mask_valid, err
    );

endinterface

// File: rtl/mask_bit_scatter.sv
// Combinational decode of one received word into per-bit write enables and
// data for the mask register: word bit i lands at mask index i*step + cnt.
module mask_bit_scatter
    import mask_pkg::*;
(
    input  res_e                        res,
    input  logic [CNT_W-1:0]            cnt,
    input  logic                        beat,
    input  logic [IP_CHANNEL_WIDTH-1:0] din,
    output logic [OP_MASK_WIDTH-1:0]    wr_en,
    output logic [OP_MASK_WIDTH-1:0]    wr_data
);

    logic [IDX_W-1:0] step;
    logic [IDX_W-1:0] idx;

    // The range guard only matters for a corrupted cnt; legal indices top out at 1079.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        idx     = '0;
        step    = IDX_W'(step_of(res));
        if (beat) begin
            for (int i = 0; i < IP_CHANNEL_WIDTH; i++) begin
                idx = IDX_W'(i) * step + IDX_W'(cnt);
                if (idx < IDX_W'(OP_MASK_WIDTH)) begin
                    wr_en[idx]   = 1'b1;
                    wr_data[idx] = din[i];
                end
            end
        end
    end

endmodule

// File: rtl/mask_deserializer.sv
// Rebuilds the full-width mask from the serializer's strided word stream and
// holds it until the consumer acknowledges.
module mask_deserializer
    import mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mask_deserializer_if.slave bus
);

    state_e                   state;
    state_e                   next_state;
    res_e                     res_q;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         step;
    logic [OP_MASK_WIDTH-1:0] mask_q;
    logic [OP_MASK_WIDTH-1:0] wr_en;
    logic [OP_MASK_WIDTH-1:0] wr_data;
    logic                     err_q;
    logic                     beat;
    logic                     last_beat;
    logic                     accept_start;
    logic                     illegal_start;

    assign step      = step_of(res_q);
    assign beat      = bus.din_valid && (state == COLLECT);
    assign last_beat = beat && (cnt == step - CNT_W'(1));

    mask_bit_scatter u_scatter (
        .res     (res_q),
        .cnt     (cnt),
        .beat    (beat),
        .din     (bus.DIN),
        .wr_en   (wr_en),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start and mask_ack only matter in the state that owns them.
    always_comb begin
        next_state     = state;
        accept_start   = 1'b0;
        illegal_start  = 1'b0;
        bus.din_ready  = 1'b0;
        bus.mask_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (res_e'(bus.imageResolution) == RES_ILLEGAL) begin
                        illegal_start = 1'b1;
                    end else begin
                        accept_start = 1'b1;
                        next_state   = COLLECT;
                    end
                end
            end
            COLLECT: begin
                bus.din_ready = 1'b1;
                if (last_beat) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                bus.mask_valid = 1'b1;
                if (bus.mask_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= RES_320;
            cnt    <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= illegal_start;
            if (accept_start) begin
                res_q  <= res_e'(bus.imageResolution);
                cnt    <= '0;
                mask_q <= '0;
            end else if (beat) begin
                mask_q <= (mask_q & ~wr_en) | (wr_data & wr_en);
                cnt    <= last_beat ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    assign bus.DOUT = mask_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_mask_deserializer.sv
// Scoreboard bench for mask_deserializer: random masks are cut into serializer
// words, and every completed mask is checked against a whole-pattern model.
module tb_mask_deserializer;
    import mask_pkg::*;

    typedef struct {
        logic [OP_MASK_WIDTH-1:0] mask;
        int                       latency;
        int                       startEdge;
    } expect_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mask_deserializer_if bus();

    mask_deserializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    expect_t                  sbQueue[$];
    logic [OP_MASK_WIDTH-1:0] lastExpected = '0;
    int                       testsRun     = 0;
    int                       failures     = 0;
    int                       edgeCnt      = 0;
    int                       beatCnt      = 0;
    int                       errSeen      = 0;
    int                       errExpected  = 0;
    logic                     prevValid    = 1'b0;

    always @(posedge clk) edgeCnt++;

    function automatic int stepFor(input logic [1:0] res);
        case (res)
            2'b00:   return STEP_SEL0;
            2'b01:   return STEP_SEL1;
            default: return STEP_SEL2;
        endcase
    endfunction

    // Serializer model: after k shifts, output bit i carries pattern[i*step+k].
    function automatic logic [IP_CHANNEL_WIDTH-1:0] wordOf(input logic [OP_MASK_WIDTH-1:0] p,
                                                           input int step, input int k);
        logic [IP_CHANNEL_WIDTH-1:0] w;
        for (int i = 0; i < IP_CHANNEL_WIDTH; i++) w[i] = p[i*step + k];
        return w;
    endfunction

    function automatic logic [OP_MASK_WIDTH-1:0] expectMask(input logic [OP_MASK_WIDTH-1:0] p,
                                                            input int step);
        logic [OP_MASK_WIDTH-1:0] keep;
        keep = '1;
        keep = keep >> (OP_MASK_WIDTH - IP_CHANNEL_WIDTH * step);
        return p & keep;
    endfunction

    function automatic logic [OP_MASK_WIDTH-1:0] randPattern();
        logic [OP_MASK_WIDTH-1:0] p;
        for (int b = 0; b < OP_MASK_WIDTH; b++) p[b] = 1'($urandom);
        return p;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        testsRun++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
        end
    endtask

    task automatic checkWide(input string name, input logic [OP_MASK_WIDTH-1:0] actual,
                             input logic [OP_MASK_WIDTH-1:0] required);
        int firstBit;
        int diffBits;
        testsRun++;
        if (actual !== required) begin
            firstBit = -1;
            diffBits = 0;
            for (int b = 0; b < OP_MASK_WIDTH; b++) begin
                if (actual[b] !== required[b]) begin
                    diffBits++;
                    if (firstBit < 0) firstBit = b;
                end
            end
            failures++;
            $display("[TB] FAIL %s: %0d bits differ, first at bit %0d actual %b required %b",
                     name, diffBits, firstBit, actual[firstBit], required[firstBit]);
        end
    endtask

    // Monitor: sampled mid-cycle, so inputs and registered outputs are both settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (bus.din_valid && bus.din_ready) beatCnt++;
            if (bus.err) errSeen++;
            if (bus.mask_valid && !prevValid) begin
                if (sbQueue.size() == 0) begin
                    testsRun++;
                    failures++;
                    $display("[TB] FAIL unexpectedMask: actual mask_valid 1 required 0");
                end else begin
                    expect_t e;
                    e = sbQueue.pop_front();
                    checkWide("dout", bus.DOUT, e.mask);
                    if (e.latency >= 0) checkOutput("latency", edgeCnt - e.startEdge + 1, e.latency);
                end
            end
            prevValid = bus.mask_valid;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBeat(input logic [IP_CHANNEL_WIDTH-1:0] w);
        int guard = 0;
        bus.DIN       = w;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && guard < 50) begin
            nextCycle();
            guard++;
        end
        if (guard == 50) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL beatTimeout: din_ready actual 0 required 1");
        end
        nextCycle();
        bus.din_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] res, input logic [OP_MASK_WIDTH-1:0] pattern,
                                 input int gapEvery, input bit noise, input int stopAfter);
        int      step;
        int      cyc = 0;
        expect_t e;
        step                = stepFor(res);
        bus.start           = 1'b1;
        bus.imageResolution = res;
        e.mask              = expectMask(pattern, step);
        e.latency           = (gapEvery == 0) ? step + 1 : -1;
        e.startEdge         = edgeCnt + 1;
        sbQueue.push_back(e);
        lastExpected        = e.mask;
        beatCnt             = 0;
        nextCycle();
        bus.start           = 1'b0;
        bus.imageResolution = 2'($urandom);
        for (int k = 0; k < step; k++) begin
            if (k == stopAfter) return;
            if (gapEvery > 0 && (cyc % gapEvery) == gapEvery - 1) begin
                bus.din_valid = 1'b0;
                nextCycle();
                cyc++;
            end
            if (noise) begin
                bus.start           = 1'($urandom);
                bus.mask_ack        = 1'($urandom);
                bus.imageResolution = 2'($urandom);
            end
            sendBeat(wordOf(pattern, step, k));
            cyc++;
            bus.start    = 1'b0;
            bus.mask_ack = 1'b0;
        end
    endtask

    task automatic waitMask();
        int guard = 0;
        while (!bus.mask_valid && guard < 100) begin
            nextCycle();
            guard++;
        end
        checkOutput("maskValidRise", int'(bus.mask_valid), 1);
    endtask

    // A start coinciding with the ack edge must be ignored.
    task automatic ackMask(input bit withStart);
        bus.mask_ack = 1'b1;
        if (withStart) begin
            bus.start           = 1'b1;
            bus.imageResolution = 2'b01;
        end
        nextCycle();
        bus.mask_ack = 1'b0;
        bus.start    = 1'b0;
        checkOutput("validAfterAck", int'(bus.mask_valid), 0);
        checkOutput("readyAfterAck", int'(bus.din_ready), 0);
        checkWide("doutAfterAck", bus.DOUT, lastExpected);
    endtask

    task automatic holdPhase();
        for (int c = 0; c < 10; c++) begin
            bus.din_valid       = 1'b1;
            bus.DIN             = IP_CHANNEL_WIDTH'($urandom);
            bus.start           = (c % 3 == 0);
            bus.imageResolution = 2'($urandom);
            nextCycle();
            checkOutput("holdReady", int'(bus.din_ready), 0);
            checkOutput("holdValid", int'(bus.mask_valid), 1);
            checkWide("holdDout", bus.DOUT, lastExpected);
        end
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Ready"}, int'(bus.din_ready), 0);
        checkOutput({tag, "Valid"}, int'(bus.mask_valid), 0);
        checkOutput({tag, "Err"}, int'(bus.err), 0);
        checkWide({tag, "Dout"}, bus.DOUT, '0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [OP_MASK_WIDTH-1:0] pat;
        bus.start           = 1'b0;
        bus.imageResolution = 2'b00;
        bus.DIN             = '0;
        bus.din_valid       = 1'b0;
        bus.mask_ack        = 1'b0;
        #12;
        checkResetState("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nextCycle();

        pat = randPattern();
        applyStimulus(2'b00, pat, 0, 1'b0, -1);
        waitMask();
        ackMask(1'b1);

        bus.start           = 1'b1;
        bus.imageResolution = 2'b11;
        errExpected++;
        nextCycle();
        bus.start = 1'b0;
        checkOutput("errPulse", int'(bus.err), 1);
        checkOutput("illegalReady", int'(bus.din_ready), 0);
        nextCycle();
        checkOutput("errCleared", int'(bus.err), 0);
        checkOutput("illegalReadyLater", int'(bus.din_ready), 0);
        checkWide("illegalDout", bus.DOUT, lastExpected);

        pat = '0;
        for (int i = 0; i < IP_CHANNEL_WIDTH; i++) pat[i*STEP_SEL2 + i] = 1'b1;
        applyStimulus(2'b10, pat, 3, 1'b0, -1);
        waitMask();
        checkOutput("beats1080", beatCnt, STEP_SEL2);
        ackMask(1'b0);

        pat = randPattern();
        applyStimulus(2'b01, pat, 0, 1'b1, -1);
        waitMask();
        holdPhase();
        ackMask(1'b0);
        pat = randPattern();
        applyStimulus(2'b10, pat, 0, 1'b0, -1);
        waitMask();
        ackMask(1'b1);

        pat = randPattern();
        applyStimulus(2'b01, pat, 0, 1'b0, 20);
        rst_n = 1'b0;
        #2;
        checkResetState("midReset");
        void'(sbQueue.pop_back());
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(2'b01, pat, 0, 1'b0, -1);
        waitMask();
        ackMask(1'b0);

        for (int r = 0; r < 4; r++) begin
            pat = randPattern();
            applyStimulus(2'($urandom_range(0, 2)), pat, 2 * $urandom_range(0, 2), 1'($urandom), -1);
            waitMask();
            ackMask(1'($urandom));
        end

        nextCycle();
        nextCycle();
        checkOutput("scoreboardEmpty", sbQueue.size(), 0);
        checkOutput("errPulses", errSeen, errExpected);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
